// File: rtl/loader_pkg.sv
// Shared types and constants for the UART memory loader.
// The optional checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int COUNT_BYTES    = 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CNT_HI,
    L_CNT_LO,
    L_DATA_HI,
    L_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    L_CSUM,
`endif
    L_FINISH,
    L_ERR
  } loader_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, baud counter, bit shifter and RX FSM.
// Emits a one-cycle byte_valid (good stop bit) or framing_err (low stop bit).
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK_50,
  input  logic       resetN,
  input  logic       rx_line,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  // Bring the asynchronous line into the clock domain; rx_prev feeds edge detect.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver FSM: mid-bit sampling driven by a per-bit cycle counter.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial memory loader: parses SYNC/COUNT/words from the UART and drives a
// memory write port while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115_200,
  parameter int DATA_WIDTH     = 16,
  parameter int REGISTER_COUNT = 2**12
) (
  input  logic                              CLK_50,
  input  logic                              resetN,
  input  logic                              uart_rx,
  output logic [$clog2(REGISTER_COUNT)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic                              mem_we,
  output logic                              cpu_hold,
  output logic                              load_done,
  output logic                              load_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int ADDR_W       = $clog2(REGISTER_COUNT);
  localparam logic [16:0] MAX_COUNT = 17'(REGISTER_COUNT);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = L_CSUM;
`else
  localparam loader_state_t AFTER_DATA = L_FINISH;
`endif

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          framing_err;
  loader_state_t state;
  logic [15:0]   count;
  logic [15:0]   index;
  logic [7:0]    hi_byte;
  logic [7:0]    csum;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK_50     (CLK_50),
    .resetN     (resetN),
    .rx_line    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .framing_err(framing_err)
  );

  // Loader FSM: one byte consumed per byte_valid, all outputs registered.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state      <= L_IDLE;
      count      <= '0;
      index      <= '0;
      hi_byte    <= '0;
      csum       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        L_IDLE: begin
          if (byte_valid && byte_data == LOADER_SYNC_BYTE) begin
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            index      <= '0;
            csum       <= '0;
            state      <= L_CNT_HI;
          end
        end
        L_CNT_HI: begin
          if (framing_err) state <= L_ERR;
          else if (byte_valid) begin
            count[15:8] <= byte_data;
            state       <= L_CNT_LO;
          end
        end
        L_CNT_LO: begin
          if (framing_err) state <= L_ERR;
          else if (byte_valid) begin
            count[7:0] <= byte_data;
            if ({1'b0, count[15:8], byte_data} > MAX_COUNT) state <= L_ERR;
            else if ({count[15:8], byte_data} == 16'd0) state <= AFTER_DATA;
            else state <= L_DATA_HI;
          end
        end
        L_DATA_HI: begin
          if (framing_err) state <= L_ERR;
          else if (byte_valid) begin
            hi_byte <= byte_data;
            csum    <= csum ^ byte_data;
            state   <= L_DATA_LO;
          end
        end
        L_DATA_LO: begin
          if (framing_err) state <= L_ERR;
          else if (byte_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= index[ADDR_W-1:0];
            mem_wdata <= DATA_WIDTH'({hi_byte, byte_data});
            csum      <= csum ^ byte_data;
            index     <= index + 16'd1;
            if (index + 16'd1 == count) state <= AFTER_DATA;
            else state <= L_DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        L_CSUM: begin
          if (framing_err) state <= L_ERR;
          else if (byte_valid) begin
            if (byte_data == csum) state <= L_FINISH;
            else state <= L_ERR;
          end
        end
`endif
        L_FINISH: begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
          state     <= L_IDLE;
        end
        L_ERR: begin
          load_error <= 1'b1;
          cpu_hold   <= 1'b0;
          state      <= L_IDLE;
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader (10 clocks per UART bit).
// Honours LOADER_CHECKSUM_EN by appending/expecting the checksum byte.
module tb_uart_mem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        CLK_50 = 1'b0;
  logic        resetN = 1'b0;
  logic        uart_rx = 1'b1;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [27:0] obs_w[$];
  logic        obs_hold[$];
  logic [27:0] exp_w[$];
  logic        exp_done;
  logic        exp_err;

  uart_mem_loader #(
    .CLK_FREQ      (1_000_000),
    .BAUD          (100_000),
    .DATA_WIDTH    (16),
    .REGISTER_COUNT(4096)
  ) dut (
    .CLK_50    (CLK_50),
    .resetN    (resetN),
    .uart_rx   (uart_rx),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 CLK_50 = ~CLK_50;

  // Record every write strobe together with the hold level seen at that moment.
  always @(negedge CLK_50) begin
    if (resetN && mem_we) begin
      obs_w.push_back({mem_addr, mem_wdata});
      obs_hold.push_back(cpu_hold);
    end
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 character; stop_ok=0 sends a low stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (10) @(posedge CLK_50);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(posedge CLK_50);
    end
    uart_rx = stop_ok;
    repeat (10) @(posedge CLK_50);
    uart_rx = 1'b1;
  endtask

  // Reference model: parse the byte stream by the frame rules and list the writes.
  task automatic modelFrame(input byte_q_t b, input int bad);
    int p = 0;
    int cnt;
    logic [7:0] x = 8'h00;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (p < b.size() && !(p != bad && b[p] == 8'hA5)) p++;
    p++;
    if (bad == p || bad == p + 1) begin exp_err = 1'b1; return; end
    cnt = {b[p], b[p+1]};
    p += 2;
    if (cnt > 4096) begin exp_err = 1'b1; return; end
    for (int w = 0; w < cnt; w++) begin
      if (bad == p || bad == p + 1) begin exp_err = 1'b1; return; end
      exp_w.push_back({12'(w), b[p], b[p+1]});
      x = x ^ b[p] ^ b[p+1];
      p += 2;
    end
`ifdef LOADER_CHECKSUM_EN
    if (bad == p || b[p] != x) begin exp_err = 1'b1; return; end
`endif
    exp_done = 1'b1;
  endtask

  // Send a stream, then compare writes and final status against the model.
  task automatic runFrame(input string name, input byte_q_t b, input int bad);
    int sync_pos = 0;
    modelFrame(b, bad);
    while (sync_pos < b.size() && !(sync_pos != bad && b[sync_pos] == 8'hA5)) sync_pos++;
    obs_w.delete();
    obs_hold.delete();
    for (int i = 0; i < b.size(); i++) begin
      applyStimulus(b[i], i != bad);
      if (i == sync_pos + 1 && i != bad)
        checkOutput({name, " hold_during_load"}, 32'(cpu_hold), 32'd1);
    end
    repeat (40) @(posedge CLK_50);
    @(negedge CLK_50);
    checkOutput({name, " write_count"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checkOutput($sformatf("%s write%0d", name, i), 32'(obs_w[i]), 32'(exp_w[i]));
      checkOutput($sformatf("%s hold_at_write%0d", name, i), 32'(obs_hold[i]), 32'd1);
    end
    checkOutput({name, " load_done"}, 32'(load_done), 32'(exp_done));
    checkOutput({name, " load_error"}, 32'(load_error), 32'(exp_err));
    checkOutput({name, " cpu_hold_end"}, 32'(cpu_hold), 32'd0);
  endtask

  function automatic byte_q_t withCsum(input byte_q_t b, input int data_start);
    byte_q_t r = b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = data_start; i < b.size(); i++) x ^= b[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  initial begin
    byte_q_t f;
    int junk, cnt, start;

    repeat (3) @(posedge CLK_50);
    @(negedge CLK_50);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("reset load_done", 32'(load_done), 32'd0);
    checkOutput("reset load_error", 32'(load_error), 32'd0);
    resetN = 1'b1;
    repeat (5) @(posedge CLK_50);

    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    runFrame("two_words", withCsum(f, 3), -1);

    f = '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
    runFrame("leading_junk", withCsum(f, 5), -1);

    f = '{8'hA5, 8'h10, 8'h01};
    runFrame("count_too_big", f, -1);

    f = '{8'hA5, 8'h00, 8'h01, 8'h12};
    runFrame("bad_stop", f, 3);

    // Abort mid-word with reset, then reload a clean frame.
    obs_w.delete();
    f = '{8'hA5, 8'h00, 8'h02, 8'h12};
    foreach (f[i]) applyStimulus(f[i], 1'b1);
    uart_rx = 1'b0;
    repeat (50) @(posedge CLK_50);
    @(negedge CLK_50);
    checkOutput("abort hold_before", 32'(cpu_hold), 32'd1);
    resetN  = 1'b0;
    uart_rx = 1'b1;
    #1;
    checkOutput("abort outputs", 32'({mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_error}), 32'd0);
    repeat (5) @(posedge CLK_50);
    resetN = 1'b1;
    repeat (200) @(posedge CLK_50);
    @(negedge CLK_50);
    checkOutput("abort no_write", obs_w.size(), 0);
    checkOutput("abort hold_after", 32'(cpu_hold), 32'd0);
    f = '{8'hA5, 8'h00, 8'h02, 8'h55, 8'hAA, 8'h0F, 8'hF0};
    runFrame("after_abort", withCsum(f, 3), -1);

`ifdef LOADER_CHECKSUM_EN
    f = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    runFrame("csum_ok", f, -1);
    f = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    runFrame("csum_bad", f, -1);
`endif

    // Randomised frames: junk prefix, small counts (including zero), rare oversize.
    for (int t = 0; t < 10; t++) begin
      f.delete();
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        f.push_back(jb);
      end
      f.push_back(8'hA5);
      cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(4097, 65535) : $urandom_range(0, 5);
      f.push_back(8'(cnt >> 8));
      f.push_back(8'(cnt));
      start = f.size();
      if (cnt <= 4096) begin
        for (int w = 0; w < 2 * cnt; w++) f.push_back(8'($urandom_range(0, 255)));
        f = withCsum(f, start);
`ifdef LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
`endif
      end
      runFrame($sformatf("rand%0d", t), f, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
